// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : In-order operation queue feeding an external combinational ALU,
//            followed by a registered result stage with valid/ready handshake.
//            Optional illegal op-code check enabled by ALU_ISSUE_OPCHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [3:0]  in_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_carry,
  output logic        out_zero,
  output logic [3:0]  out_op,
  output logic        out_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [35:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [15:0]   r_out_result;
  logic          r_out_carry;
  logic          r_out_zero;
  logic [3:0]    r_out_op;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_illegal;
  logic [35:0]   w_head;
  logic [15:0]   w_res;
  logic          w_carry;
  logic          w_zero;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != C_DEPTH);
  assign w_push   = in_valid && in_ready;
  // The head may advance whenever the result slot is free or being drained.
  assign w_pop    = !w_empty && (!r_out_valid || out_ready);
  assign w_head   = r_mem[r_rd_ptr];

  assign alu_op = w_empty ? 4'd0  : w_head[35:32];
  assign alu_a  = w_empty ? 16'd0 : w_head[31:16];
  assign alu_b  = w_empty ? 16'd0 : w_head[15:0];

`ifdef ALU_ISSUE_OPCHECK_EN
  logic r_out_err;

  always_comb begin
    case (alu_op)
      4'd1, 4'd2, 4'd3, 4'd5, 4'd11: w_illegal = 1'b1;
      default:                       w_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_err <= 1'b0;
    end else if (w_pop) begin
      r_out_err <= w_illegal;
    end
  end

  assign out_err = r_out_err;
`else
  assign w_illegal = 1'b0;
  assign out_err   = 1'b0;
`endif

  // Illegal ops retire as a forced zero result so downstream sees a clean value.
  assign w_res   = w_illegal ? 16'd0 : alu_result;
  assign w_carry = !w_illegal && alu_carry;
  assign w_zero  = w_illegal || alu_zero;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 16'd0;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_op     <= 4'd0;
    end else if (w_pop) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_res;
      r_out_carry  <= w_carry;
      r_out_zero   <= w_zero;
      r_out_op     <= alu_op;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_zero   = r_out_zero;
  assign out_op     = r_out_op;
  assign busy       = !w_empty || r_out_valid;

endmodule
`default_nettype wire
